// File: rtl/mic_ram_frame_writer.sv
// Ping-pong frame writer: streams samples into two halves of ram_block_s2, flags full halves to software.
// Optional MIC_FRAME_HEADER_EN: writes {frame_seq, 16'hA5A5} at offset 0 of each half before the samples.
module mic_ram_frame_writer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              frame_ack,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_clken,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic [3:0]        ram_byteenable,
  output logic              frame_valid,
  output logic              frame_half,
  output logic [15:0]       frame_seq,
  output logic [15:0]       overflow_cnt
);

  localparam int unsigned OFF_W = ADDR_W - 1;
  localparam logic [OFF_W-1:0] OFF_LAST = '1;
`ifdef MIC_FRAME_HEADER_EN
  localparam logic [15:0] HDR_TAG = 16'hA5A5;
`endif

  typedef enum logic [1:0] {IDLE, FILL, WAIT_FREE} state_t;

  state_t           state;
  logic [1:0]       pending;
  logic             fill_half;
  logic [OFF_W-1:0] offset;

  logic       can_fill;
  logic       hdr_cycle;
  logic       xfer;
  logic       complete;
  logic       ack_ok;
  logic       overflow_hit;
  logic [1:0] pending_nxt;

  assign can_fill = enable && (state == FILL) && !pending[fill_half];
`ifdef MIC_FRAME_HEADER_EN
  assign hdr_cycle = can_fill && (offset == '0);
`else
  assign hdr_cycle = 1'b0;
`endif
  assign in_ready     = can_fill && !hdr_cycle;
  assign xfer         = in_valid && in_ready;
  assign complete     = xfer && (offset == OFF_LAST);
  assign ack_ok       = frame_ack && (|pending);
  assign overflow_hit = in_valid && !in_ready && enable && (state == WAIT_FREE);

  assign ram_clken      = 1'b1;
  assign ram_byteenable = 4'b1111;
  assign frame_valid    = |pending;

  // Ack and completion always touch different halves, so both can land in one cycle.
  always_comb begin
    pending_nxt = pending;
    if (ack_ok)   pending_nxt[frame_half] = 1'b0;
    if (complete) pending_nxt[fill_half]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pending        <= 2'b00;
      fill_half      <= 1'b0;
      offset         <= '0;
      frame_half     <= 1'b0;
      frame_seq      <= 16'd0;
      overflow_cnt   <= 16'd0;
      ram_address    <= '0;
      ram_writedata  <= '0;
      ram_write      <= 1'b0;
      ram_chipselect <= 1'b0;
    end else begin
      ram_write      <= 1'b0;
      ram_chipselect <= 1'b0;
      pending        <= pending_nxt;

      if (ack_ok) frame_half <= ~frame_half;

      if (overflow_hit && (overflow_cnt != 16'hFFFF))
        overflow_cnt <= overflow_cnt + 16'd1;

`ifdef MIC_FRAME_HEADER_EN
      if (hdr_cycle) begin
        ram_write      <= 1'b1;
        ram_chipselect <= 1'b1;
        ram_address    <= {fill_half, offset};
        ram_writedata  <= DATA_W'({frame_seq, HDR_TAG});
        offset         <= offset + OFF_W'(1);
      end
`endif

      if (xfer) begin
        ram_write      <= 1'b1;
        ram_chipselect <= 1'b1;
        ram_address    <= {fill_half, offset};
        ram_writedata  <= in_data;
        if (offset == OFF_LAST) begin
          frame_seq <= frame_seq + 16'd1;
          fill_half <= ~fill_half;
          offset    <= '0;
        end else begin
          offset <= offset + OFF_W'(1);
        end
      end

      case (state)
        IDLE:      if (enable) state <= FILL;
        FILL:      if (complete && pending_nxt[~fill_half]) state <= WAIT_FREE;
        WAIT_FREE: if (!pending[fill_half]) state <= FILL;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mic_ram_frame_writer.sv
// Self-checking bench for mic_ram_frame_writer: directed ping-pong scenarios plus random traffic
// against a per-cycle behavioural model of the frame/ack rules.
module tb_mic_ram_frame_writer;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int HALF = 1 << (ADDR_W - 1);
`ifdef MIC_FRAME_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              frame_ack;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_clken;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic [3:0]        ram_byteenable;
  logic              frame_valid;
  logic              frame_half;
  logic [15:0]       frame_seq;
  logic [15:0]       overflow_cnt;

  mic_ram_frame_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .frame_ack(frame_ack),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_clken(ram_clken),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
    .frame_valid(frame_valid), .frame_half(frame_half), .frame_seq(frame_seq),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: has capture started, is it blocked waiting for a free half, which halves are full.
  bit          m_started;
  bit          m_wait;
  bit [1:0]    m_pend;
  int          m_fill;
  int          m_rd;
  int          m_off;
  logic [15:0] m_seq;
  logic [15:0] m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_wait    = 1'b0;
    m_pend    = 2'b00;
    m_fill    = 0;
    m_rd      = 0;
    m_off     = 0;
    m_seq     = 16'd0;
    m_ovf     = 16'd0;
  endtask

  function automatic bit m_can_fill(input bit en);
    return en && m_started && !m_wait && !m_pend[m_fill];
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_write"}, 32'(ram_write), 32'd0);
    chk({tag, "_cs"}, 32'(ram_chipselect), 32'd0);
    chk({tag, "_addr"}, 32'(ram_address), 32'd0);
    chk({tag, "_wdata"}, ram_writedata, 32'd0);
    chk({tag, "_clken"}, 32'(ram_clken), 32'd1);
    chk({tag, "_be"}, 32'(ram_byteenable), 32'hF);
    chk({tag, "_fvalid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_fhalf"}, 32'(frame_half), 32'd0);
    chk({tag, "_fseq"}, 32'(frame_seq), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow_cnt), 32'd0);
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic step(input bit en, input bit v, input bit ack, input logic [31:0] d);
    bit can, hdr, rdy, xfer, ovf, wclr, ack_ok, exp_wr;
    logic [31:0] exp_addr, exp_data;
    enable = en; in_valid = v; frame_ack = ack; in_data = d;
    #1;
    can  = m_can_fill(en);
    hdr  = HDR && can && (m_off == 0);
    rdy  = can && !hdr;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    xfer     = v && rdy;
    ovf      = v && !rdy && en && m_wait;
    exp_wr   = xfer || hdr;
    exp_addr = 32'(m_fill * HALF + m_off);
    exp_data = hdr ? {m_seq, 16'hA5A5} : d;
    wclr     = m_wait && !m_pend[m_fill];
    ack_ok   = ack && (m_pend != 2'b00);
    if (ack_ok) begin
      m_pend[m_rd] = 1'b0;
      m_rd ^= 1;
    end
    if (hdr) m_off++;
    if (xfer) begin
      if (m_off == HALF - 1) begin
        m_pend[m_fill] = 1'b1;
        m_seq++;
        m_fill ^= 1;
        m_off = 0;
        if (m_pend[m_fill]) m_wait = 1'b1;
      end else begin
        m_off++;
      end
    end
    if (wclr) m_wait = 1'b0;
    if (en) m_started = 1'b1;
    if (ovf && m_ovf != 16'hFFFF) m_ovf++;
    @(posedge clk); #1;
    chk("ram_write", 32'(ram_write), 32'(exp_wr));
    chk("ram_chipselect", 32'(ram_chipselect), 32'(exp_wr));
    if (exp_wr) begin
      chk("ram_address", 32'(ram_address), exp_addr);
      chk("ram_writedata", ram_writedata, exp_data);
    end
    chk("frame_valid", 32'(frame_valid), 32'(m_pend != 2'b00));
    chk("frame_half", 32'(frame_half), 32'(m_rd));
    chk("frame_seq", 32'(frame_seq), 32'(m_seq));
    chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
  endtask

  initial begin
    logic [31:0] k;
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; frame_ack = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Stream a counting sequence with no ack: both halves fill, then block and count overflow.
    k = 0;
    for (int i = 0; i < 22; i++) begin
      bit r;
      r = m_can_fill(1'b1) && !(HDR && m_off == 0);
      step(1'b1, 1'b1, 1'b0, k);
      if (r) k++;
    end
`ifndef MIC_FRAME_HEADER_EN
    chk("plan_seq2", 32'(frame_seq), 32'd2);
    chk("plan_ovf5", 32'(overflow_cnt), 32'd5);
    chk("plan_half0", 32'(frame_half), 32'd0);
`endif

    // Ack half 0 while blocked; refill half 0 and block again on half 1.
    step(1'b1, 1'b1, 1'b1, $urandom);
`ifndef MIC_FRAME_HEADER_EN
    chk("ack_half1", 32'(frame_half), 32'd1);
`endif
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, $urandom);

    // Free half 1, then ack half 0 on the same cycle half 1 completes.
    step(1'b1, 1'b1, 1'b1, $urandom);
    for (int i = 0; i < 9; i++) begin
      bit coinc;
      coinc = (m_fill == 1) && (m_off == HALF - 1) && m_pend[0] && m_can_fill(1'b1);
      step(1'b1, 1'b1, coinc, $urandom);
    end
`ifndef MIC_FRAME_HEADER_EN
    chk("coinc_valid", 32'(frame_valid), 32'd1);
    chk("coinc_half", 32'(frame_half), 32'd1);
    chk("coinc_seq", 32'(frame_seq), 32'd4);
`endif

    // Pause capture mid-frame and resume at the same offset.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b0, $urandom);
`ifndef MIC_FRAME_HEADER_EN
    chk("resume_addr", 32'(ram_address), 32'd3);
`endif
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, $urandom);

    // Asynchronous reset mid-frame, away from the clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    enable = 1'b0; in_valid = 1'b0; frame_ack = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b0, $urandom);
    chk("post_rst_addr0", 32'(ram_address), 32'd0);

    // Random traffic with sporadic enable drops and acks.
    for (int i = 0; i < 400; i++)
      step(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 6) == 0, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic_ram_frame_writer.md
Name: mic_ram_frame_writer

Overview:
- Sequences writes into the on-chip RAM's second Avalon port (ram_block_s2) from a streaming sample source, such as mic array decimator output.
- Splits the RAM into two ping-pong halves. Fills one half while the Nios/TSE path drains the other.
- Flags each completed half to software and waits for an acknowledge before reusing it.
- Sits between the sample pipeline and the nios_system ram_block_s2 port, on sys_clk.

Parameters:
- ADDR_W, 10, RAM word address width. Total depth is 2^ADDR_W words; half depth is HALF = 2^(ADDR_W-1).
- DATA_W, 32, sample/RAM word width. Fixed at 32 by the byteenable width.

Ports:
- clk  in  1  system clock (sys_clk domain)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable
- in_valid  in  1  sample valid
- in_data  in  DATA_W  sample word
- in_ready  out  1  block accepts sample this cycle
- frame_ack  in  1  one-cycle pulse from software: oldest pending half has been consumed
- ram_address  out  ADDR_W  to ram_block_s2_address
- ram_chipselect  out  1  to ram_block_s2_chipselect
- ram_clken  out  1  to ram_block_s2_clken; tied 1
- ram_write  out  1  to ram_block_s2_write
- ram_writedata  out  DATA_W  to ram_block_s2_writedata
- ram_byteenable  out  4  to ram_block_s2_byteenable; constant 4'b1111
- frame_valid  out  1  at least one half is full and pending
- frame_half  out  1  index of the oldest pending half
- frame_seq  out  16  count of completed frames, wraps at 16'hFFFF -> 0
- overflow_cnt  out  16  samples offered while blocked; saturates at 16'hFFFF

Behaviour:
- Reset values:
  - All registered outputs are 0, except ram_clken = 1 and ram_byteenable = 4'b1111.
  - pending[1:0] = 0, fill half = 0, offset = 0.
  - FSM is in IDLE.
  - RAM contents are not cleared.
- Handshake:
  - A sample transfers when in_valid && in_ready.
  - in_ready = enable && (state == FILL) && !pending[fill_half], with no header write in that cycle.
- Write timing:
  - Writes are registered. A transfer at cycle N drives ram_write = ram_chipselect = 1 at N+1.
  - ram_address = {fill_half, offset}; ram_writedata = in_data.
  - ram_write and ram_chipselect are 0 on all other cycles.
- FSM states:
  - IDLE: waits for enable = 1, then goes to FILL.
  - FILL:
    - Each transfer increments offset.
    - On the transfer at offset HALF-1: set pending[fill_half], increment frame_seq, toggle fill_half, set offset = 0.
    - If the new fill_half is already pending, go to WAIT_FREE.
  - WAIT_FREE: in_ready = 0. Returns to FILL in the cycle after pending[fill_half] clears.
- enable low mid-frame:
  - in_ready drops; offset and fill_half are held.
  - Re-asserting enable resumes at the same offset. No return to IDLE.
- Overflow:
  - Counts in_valid cycles with in_ready = 0 while enable = 1 and state == WAIT_FREE.
  - Saturates at 16'hFFFF.
- Ack:
  - frame_ack clears pending[frame_half]; frame_half then toggles.
  - frame_ack with pending == 0 is ignored.
- Status:
  - frame_valid = |pending.
  - frame_half is a read pointer and advances only on a valid ack.
- Simultaneous completion and ack in the same cycle: both take effect. No lost frame and no spurious WAIT_FREE.
- Async reset mid-frame aborts immediately. A partially written half is abandoned and is not flagged.

Optional Feature:
- Macro: MIC_FRAME_HEADER_EN.
- Defined:
  - On entry to each half (offset 0), the block writes a header word {frame_seq, 16'hA5A5} at offset 0.
  - in_ready = 0 during that single header cycle.
  - Samples then occupy offsets 1..HALF-1, i.e. HALF-1 samples per frame.
  - frame_seq in the header is the pre-increment value, i.e. the index of the frame being filled.
- Undefined: no header; all HALF offsets hold samples.

Test Plan:
- ADDR_W=4, enable=1, in_valid held high with in_data = 0,1,2,… -> writes to addresses 0..7 with data 0..7, each one cycle after its transfer; frame_valid=1, frame_half=0, frame_seq=1 after the 8th transfer.
- Continue streaming with no ack -> addresses 8..15 receive 8..15; then WAIT_FREE with in_ready=0; holding in_valid 5 more cycles -> overflow_cnt=5.
- Pulse frame_ack in WAIT_FREE -> frame_half becomes 1; in_ready rises the cycle after pending[0] clears; next sample is written at address 0.
- frame_ack coincident with the 8th write of half 1 while half 0 is pending -> pending becomes {1,0} (half 1 pending, half 0 cleared); no WAIT_FREE entry; frame_seq increments.
- Drop enable after 3 transfers, hold 4 cycles, re-enable -> the next write goes to address 3; no writes during the gap. Assert reset_n=0 mid-frame -> all outputs at reset values; the next frame starts at address 0.
- With MIC_FRAME_HEADER_EN defined, ADDR_W=4 -> address 0 gets 32'h0000A5A5; samples 0..6 go to addresses 1..7; address 8 gets 32'h0001A5A5.
